// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller and the exception unit that feeds it.
// Cause codes are common to both blocks so a saved cause can be decoded anywhere.
package trap_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT,
        ST_HANDLER,
        ST_RETURN,
        ST_HALT
    } trap_state_t;

    localparam logic [3:0] CAUSE_IRQ  = 4'hF;
    localparam logic [3:0] CAUSE_DIV0 = 4'd1;

    localparam logic [4:0] OPCODE_DIV = 5'b00011;

endpackage

// File: rtl/trap_controller.sv
// Trap sequencer: flushes the pipeline, saves EPC/cause, redirects fetch to the
// trap vector and restores the saved PC on return-from-exception.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exception_i,
    input  logic [3:0]      exception_code_i,
    input  logic            irq_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic            eret_i,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [XLEN-1:0] epc_o,
    output logic [3:0]      cause_o,
    output logic            in_trap_o,
    output logic            halt_o
);

    localparam int                CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    trap_state_t      state;
    logic [CNT_W-1:0] flush_cnt;

    // Every output is a register so fetch and the pipeline see glitch-free strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            flush_cnt        <= '0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            epc_o            <= '0;
            cause_o          <= '0;
            in_trap_o        <= 1'b0;
            halt_o           <= 1'b0;
        end else begin
            redirect_valid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (exception_i) begin
                        epc_o     <= exc_pc_i;
                        cause_o   <= exception_code_i;
                        flush_cnt <= '0;
                        flush_o   <= 1'b1;
                        state     <= ST_FLUSH;
                    end else if (irq_i) begin
                        epc_o     <= exc_pc_i;
                        cause_o   <= CAUSE_IRQ;
                        flush_cnt <= '0;
                        flush_o   <= 1'b1;
                        state     <= ST_FLUSH;
                    end
                end
                // Requests seen here come from instructions being killed, so they are dropped.
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + CNT_W'(1);
                    if (flush_cnt == CNT_LAST) begin
                        flush_o          <= 1'b0;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= TRAP_VECTOR;
                        state            <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    in_trap_o <= 1'b1;
                    state     <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (exception_i) begin
                        halt_o    <= 1'b1;
                        flush_o   <= 1'b1;
                        in_trap_o <= 1'b0;
                        state     <= ST_HALT;
                    end else if (eret_i) begin
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= epc_o;
                        in_trap_o        <= 1'b0;
                        state            <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    state <= ST_IDLE;
                end
                ST_HALT: begin
                    halt_o  <= 1'b1;
                    flush_o <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller; redirect targets are predicted into a
// queue when a trap or return is requested and checked when the strobe appears.
module tb_trap_controller;
    import trap_controller_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        exception_i;
    logic [3:0]  exception_code_i;
    logic        irq_i;
    logic [31:0] exc_pc_i;
    logic        eret_i;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] epc_o;
    logic [3:0]  cause_o;
    logic        in_trap_o;
    logic        halt_o;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_redirect_q[$];

    trap_controller #(
        .XLEN         (32),
        .TRAP_VECTOR  (32'h0000_0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exception_i      (exception_i),
        .exception_code_i (exception_code_i),
        .irq_i            (irq_i),
        .exc_pc_i         (exc_pc_i),
        .eret_i           (eret_i),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .epc_o            (epc_o),
        .cause_o          (cause_o),
        .in_trap_o        (in_trap_o),
        .halt_o           (halt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic exc, input logic [3:0] code, input logic irq,
                                 input logic [31:0] pc, input logic eret);
        exception_i      = exc;
        exception_code_i = code;
        irq_i            = irq;
        exc_pc_i         = pc;
        eret_i           = eret;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_flush"},   {31'd0, flush_o},          32'd0);
        checkOutput({tag, "_rv"},      {31'd0, redirect_valid_o}, 32'd0);
        checkOutput({tag, "_rpc"},     redirect_pc_o,             32'd0);
        checkOutput({tag, "_epc"},     epc_o,                     32'd0);
        checkOutput({tag, "_cause"},   {28'd0, cause_o},          32'd0);
        checkOutput({tag, "_in_trap"}, {31'd0, in_trap_o},        32'd0);
        checkOutput({tag, "_halt"},    {31'd0, halt_o},           32'd0);
    endtask

    // Scoreboard: each redirect strobe must match the oldest predicted target.
    always @(negedge clk) begin
        if (rst_n && redirect_valid_o) begin
            if (exp_redirect_q.size() == 0) begin
                checkOutput("unexpected_redirect", redirect_pc_o, 32'hFFFF_FFFF);
            end else begin
                checkOutput("redirect_pc", redirect_pc_o, exp_redirect_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        checkIdleOutputs("reset");
        rst_n = 1'b1;

        // Divide by zero, with a stray exception during FLUSH that must be dropped
        applyStimulus(1'b1, CAUSE_DIV0, 1'b0, 32'h40, 1'b0);
        exp_redirect_q.push_back(32'h100);
        tick();
        checkOutput("div0_flush1", {31'd0, flush_o}, 32'd1);
        applyStimulus(1'b1, 4'd3, 1'b1, 32'h99, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("div0_flush2", {31'd0, flush_o}, 32'd1);
        checkOutput("flush_ignore_epc", epc_o, 32'h40);
        tick();
        checkOutput("div0_flush_off", {31'd0, flush_o}, 32'd0);
        checkOutput("div0_rv", {31'd0, redirect_valid_o}, 32'd1);
        checkOutput("div0_rpc", redirect_pc_o, 32'h100);
        tick();
        checkOutput("div0_in_trap", {31'd0, in_trap_o}, 32'd1);
        checkOutput("div0_rv_off", {31'd0, redirect_valid_o}, 32'd0);
        checkOutput("div0_epc", epc_o, 32'h40);
        checkOutput("div0_cause", {28'd0, cause_o}, 32'd1);

        // Interrupts are masked while the handler runs
        applyStimulus(1'b0, 4'd0, 1'b1, 32'h77, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("mask_flush", {31'd0, flush_o}, 32'd0);
            checkOutput("mask_in_trap", {31'd0, in_trap_o}, 32'd1);
        end
        checkOutput("mask_epc", epc_o, 32'h40);

        // Return from exception
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
        exp_redirect_q.push_back(32'h40);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("eret_rv", {31'd0, redirect_valid_o}, 32'd1);
        checkOutput("eret_rpc", redirect_pc_o, 32'h40);
        checkOutput("eret_in_trap", {31'd0, in_trap_o}, 32'd0);
        tick();
        checkOutput("eret_rv_off", {31'd0, redirect_valid_o}, 32'd0);
        checkOutput("eret_rpc_hold", redirect_pc_o, 32'h40);
        checkOutput("eret_cause_kept", {28'd0, cause_o}, 32'd1);

        // Exception wins over a simultaneous interrupt
        applyStimulus(1'b1, CAUSE_DIV0, 1'b1, 32'h80, 1'b0);
        exp_redirect_q.push_back(32'h100);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("simul_cause", {28'd0, cause_o}, 32'd1);
        checkOutput("simul_epc", epc_o, 32'h80);
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
        exp_redirect_q.push_back(32'h80);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        tick();

        // Interrupt alone
        applyStimulus(1'b0, 4'd7, 1'b1, 32'h200, 1'b0);
        exp_redirect_q.push_back(32'h100);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("irq_cause", {28'd0, cause_o}, 32'hF);
        checkOutput("irq_epc", epc_o, 32'h200);
        checkOutput("irq_in_trap", {31'd0, in_trap_o}, 32'd1);

        // Double fault: core stays halted and flushing
        applyStimulus(1'b1, 4'd5, 1'b0, 32'h300, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 22; i++) begin
            checkOutput("dfault_halt", {31'd0, halt_o}, 32'd1);
            checkOutput("dfault_flush", {31'd0, flush_o}, 32'd1);
            tick();
        end
        checkOutput("dfault_epc", epc_o, 32'h200);
        checkOutput("dfault_cause", {28'd0, cause_o}, 32'hF);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkIdleOutputs("halt_reset");

        // Reset at the second flush edge aborts the trap with no redirect
        applyStimulus(1'b1, 4'd2, 1'b0, 32'h44, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("rflush_flush", {31'd0, flush_o}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkIdleOutputs("rflush");
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rflush_no_rv", {31'd0, redirect_valid_o}, 32'd0);
        end

        // Double fault with exception and eret together
        applyStimulus(1'b0, 4'd0, 1'b1, 32'h500, 1'b0);
        exp_redirect_q.push_back(32'h100);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 4'd6, 1'b0, 32'h600, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("dfault2_halt", {31'd0, halt_o}, 32'd1);
            checkOutput("dfault2_rv", {31'd0, redirect_valid_o}, 32'd0);
        end
        checkOutput("dfault2_epc", epc_o, 32'h500);

        checkOutput("scoreboard_empty", exp_redirect_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
Sequences the core's response to a raised exception or external interrupt. Consumes exception/exception_code from the exception unit, flushes the pipeline, saves the faulting PC and cause, redirects fetch to the trap vector, and restores the PC on a return-from-exception. It sits between the exception unit and the fetch/PC stage.

Parameters:
XLEN, 32, PC/EPC width
TRAP_VECTOR, 32'h0000_0100, handler entry address
FLUSH_CYCLES, 2, cycles flush_o is held before the redirect (legal range 1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
exception_i  input  1  exception raised this cycle (from exception unit)
exception_code_i  input  4  cause code accompanying exception_i
irq_i  input  1  external interrupt request, level
exc_pc_i  input  XLEN  PC of the instruction in EX this cycle
eret_i  input  1  return-from-exception instruction retiring
flush_o  output  1  kill all in-flight pipeline stages
redirect_valid_o  output  1  one-cycle strobe: load redirect_pc_o into the PC
redirect_pc_o  output  XLEN  redirect target
epc_o  output  XLEN  saved exception PC
cause_o  output  4  saved cause; 4'hF = interrupt
in_trap_o  output  1  handler running; interrupts masked
halt_o  output  1  double fault; core stopped (sticky)

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, flush counter=0. All outputs 0: epc_o=0, cause_o=0, redirect_pc_o=0. Reset mid-sequence aborts it with no redirect.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT.
- IDLE: exception_i=1 -> capture epc<=exc_pc_i, cause<=exception_code_i, next FLUSH. Otherwise irq_i=1 -> capture epc<=exc_pc_i, cause<=4'hF, next FLUSH. Exception has priority over irq. eret_i is ignored in IDLE.
- FLUSH: flush_o=1 and the counter increments. After FLUSH_CYCLES cycles in FLUSH, next REDIRECT. exception_i, irq_i and eret_i are ignored because they come from flushed instructions.
- REDIRECT: redirect_valid_o=1 and redirect_pc_o=TRAP_VECTOR for exactly one cycle; flush_o=0. Next HANDLER.
- HANDLER: in_trap_o=1 and irq_i is ignored.
  - exception_i=1 -> HALT (double fault); epc/cause are not overwritten.
  - Else eret_i=1 -> RETURN.
  - exception_i and eret_i together -> HALT.
- RETURN: redirect_valid_o=1 and redirect_pc_o=epc_o for one cycle; in_trap_o=0. Next IDLE. epc_o and cause_o keep their values until the next capture.
- HALT: halt_o=1 and flush_o=1 continuously; no redirect. The only exit is reset.
- All outputs are registered (Moore). Latency for an event sampled at edge N:
  - flush_o high for edges N+1 .. N+FLUSH_CYCLES;
  - redirect at edge N+FLUSH_CYCLES+1;
  - in_trap_o from N+FLUSH_CYCLES+2.
- The flush counter is $clog2(FLUSH_CYCLES+1) bits and clears on FLUSH entry; no wrap is possible.
- redirect_pc_o holds its last value when redirect_valid_o=0.

Decomposition:
- Shared package: state enum, CAUSE_IRQ=4'hF, CAUSE_DIV0=4'd1, opcode constant 5'b00011 (DIV). The exception unit uses the same cause codes.
- Single module; no sub-module needed. The FSM and EPC/cause registers are small enough to keep flat.

Test Plan:
- Divide by zero: exception_i=1, code=1, exc_pc_i=0x40 at edge 5 -> flush_o high edges 6–7; redirect_valid_o=1 with pc=0x100 at edge 8; in_trap_o=1 from edge 9; epc_o=0x40, cause_o=1.
- Return: in HANDLER, eret_i=1 -> next edge redirect_valid_o=1, redirect_pc_o=0x40; then IDLE with in_trap_o=0.
- Simultaneous: exception_i=1 (code 1) and irq_i=1 in IDLE -> cause_o=1, not 0xF. A later irq-only event -> cause_o=0xF.
- Masking: irq_i held high in HANDLER -> no state change, no flush. Exceptions during FLUSH are ignored and epc_o is unchanged.
- Double fault: exception_i in HANDLER (also with eret_i=1) -> halt_o=1 and flush_o=1 held for 20+ cycles; epc_o and cause_o keep their first values.
- Reset in FLUSH: rst_n=0 at the second flush edge -> all outputs 0 next edge, and no redirect_valid_o pulse ever appears.
